// File: rtl/jk_bank_driver_if.sv
// Target stream between a sequencing master and the JK bank driver.
// Latency: none (wires only).
// Backpressure: the master holds tgt_valid/tgt_data/tgt_mode until tgt_ready is seen.
//
// Signals:
//   tgt_valid  master -> driver  target vector offered
//   tgt_ready  driver -> master  driver can take a target
//   tgt_data   master -> driver  requested next Q value per flop
//   tgt_mode   master -> driver  0 = set/reset excitation, 1 = toggle changing bits
interface jk_bank_driver_if #(
  parameter int N = 4
);
  logic         tgt_valid;
  logic         tgt_ready;
  logic [N-1:0] tgt_data;
  logic         tgt_mode;

  modport master (output tgt_valid, output tgt_data, output tgt_mode, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, input tgt_mode, output tgt_ready);
endinterface

// File: rtl/jk_bank_driver.sv
// Drives a bank of N JK flops to a requested vector, then checks the Q/QBAR feedback.
// Latency: acceptance edge to done pulse = 2 + SETTLE cycles.
// Backpressure: tgt_ready is high only in IDLE; targets offered while busy wait.
//
// Ports:
//   clock, reset_n     shared clock, async active-low reset
//   tgt                target stream (slave side)
//   j, k               registered excitation to the bank
//   q_fb, qbar_fb      bank feedback
//   busy, done         not-idle flag, one-cycle check-complete pulse
//   err, err_clr       sticky mismatch flag and its synchronous clear
//   mismatch_count     saturating count of failed checks
module jk_bank_driver #(
  parameter int N          = 4,
  parameter int SETTLE     = 1,
  parameter int CW         = 8,
  parameter bit CHECK_QBAR = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  jk_bank_driver_if.slave       tgt,
  output logic [N-1:0]          j,
  output logic [N-1:0]          k,
  input  logic [N-1:0]          q_fb,
  input  logic [N-1:0]          qbar_fb,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  err_clr,
  output logic [CW-1:0]         mismatch_count
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK
  } state_t;

  localparam logic [3:0]    SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t         state;
  logic [N-1:0]   shadow;     // what the bank is believed to hold
  logic [N-1:0]   tgt_r;
  logic [3:0]     wait_cnt;

  logic [N-1:0]   toggle;
  logic [N-1:0]   drive_j;
  logic [N-1:0]   drive_k;
  logic           pass;

  // Excitation for the DRIVE cycle, computed from the target as it is accepted.
  // Toggle mode: changing bits get J=K=1, steady bits get explicit set/reset from
  // shadow, so J=K=0 never appears on any bit.
  always_comb begin
    toggle  = tgt.tgt_data ^ shadow;
    drive_j = tgt.tgt_data;
    drive_k = ~tgt.tgt_data;
    if (tgt.tgt_mode) begin
      drive_j = toggle | shadow;
      drive_k = toggle | ~shadow;
    end
  end

  always_comb begin
    pass = (q_fb == tgt_r) && (!CHECK_QBAR || (qbar_fb == ~tgt_r));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_INIT;
      shadow         <= '0;
      tgt_r          <= '0;
      wait_cnt       <= '0;
      j              <= '0;
      k              <= '1;
      tgt.tgt_ready  <= 1'b0;
      busy           <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
      mismatch_count <= '0;
    end else begin
      done <= 1'b0;

      // A failing check in the same cycle overrides this below.
      if (err_clr) begin
        err            <= 1'b0;
        mismatch_count <= '0;
      end

      case (state)
        S_INIT: begin
          // The reset pattern (j=0, k=1) has cleared the bank for one full cycle.
          j             <= shadow;
          k             <= ~shadow;
          tgt.tgt_ready <= 1'b1;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end

        S_IDLE: begin
          if (tgt.tgt_valid && tgt.tgt_ready) begin
            tgt_r         <= tgt.tgt_data;
            j             <= drive_j;
            k             <= drive_k;
            tgt.tgt_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          // The bank takes the excitation on this edge; fall back to explicit hold.
          shadow   <= tgt_r;
          j        <= tgt_r;
          k        <= ~tgt_r;
          wait_cnt <= SETTLE_M1;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_CHECK: begin
          done          <= 1'b1;
          tgt.tgt_ready <= 1'b1;
          busy          <= 1'b0;
          state         <= S_IDLE;
          if (!pass) begin
            err <= 1'b1;
            if (err_clr) begin
              mismatch_count <= CNT_ONE;
            end else if (mismatch_count != '1) begin
              mismatch_count <= mismatch_count + CNT_ONE;
            end
          end
        end

        default: begin
          j             <= '0;
          k             <= '1;
          tgt.tgt_ready <= 1'b0;
          busy          <= 1'b1;
          state         <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
module tb_jk_bank_driver;
  localparam int N      = 4;
  localparam int SETTLE = 1;
  localparam int CW     = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  jk_bank_driver_if #(.N(N)) tgt_if ();

  logic [N-1:0]  j, k, q_fb, qbar_fb;
  logic          busy, done, err, err_clr;
  logic [CW-1:0] mismatch_count;

  jk_bank_driver #(.N(N), .SETTLE(SETTLE), .CW(CW), .CHECK_QBAR(1'b1)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .tgt            (tgt_if),
    .j              (j),
    .k              (k),
    .q_fb           (q_fb),
    .qbar_fb        (qbar_fb),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_clr        (err_clr),
    .mismatch_count (mismatch_count)
  );

  // Behavioural JK bank; fault_mask forces feedback bits stuck at 1.
  logic [N-1:0] bank_q = '0;
  logic [N-1:0] fault_mask = '0;
  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      case ({j[i], k[i]})
        2'b10:   bank_q[i] <= 1'b1;
        2'b01:   bank_q[i] <= 1'b0;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: ;
      endcase
    end
  end
  assign q_fb    = bank_q | fault_mask;
  assign qbar_fb = ~q_fb;

  typedef struct {
    logic [N-1:0]  tgt;
    int            acc;
    logic          exp_err;
    logic [CW-1:0] exp_cnt;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [N-1:0]  shadow_m = '0;
  logic          err_m = 1'b0;
  logic [CW-1:0] cnt_m = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every done pulse retires the oldest accepted target.
  always @(negedge clock) begin : mon
    sb_t e;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done at cycle %0d with empty scoreboard", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (cyc - e.acc != 2 + SETTLE) begin
          errors++;
          $display("FAIL done_latency tgt=%b got %0d exp %0d", e.tgt, cyc - e.acc, 2 + SETTLE);
        end
        checks++;
        if (err !== e.exp_err) begin
          errors++;
          $display("FAIL done_err tgt=%b got %b exp %b", e.tgt, err, e.exp_err);
        end
        checks++;
        if (mismatch_count !== e.exp_cnt) begin
          errors++;
          $display("FAIL done_count tgt=%b got %0d exp %0d", e.tgt, mismatch_count, e.exp_cnt);
        end
      end
    end
  end

  // Independent per-bit excitation model.
  function automatic void exc(input logic [N-1:0] t, input logic [N-1:0] sh, input logic m,
                              output logic [N-1:0] ej, output logic [N-1:0] ek);
    for (int i = 0; i < N; i++) begin
      if (m && (t[i] != sh[i])) begin
        ej[i] = 1'b1; ek[i] = 1'b1;
      end else if (m) begin
        ej[i] = sh[i]; ek[i] = !sh[i];
      end else begin
        ej[i] = t[i]; ek[i] = !t[i];
      end
    end
  endfunction

  // Update the result model for one check and build its scoreboard entry.
  function automatic sb_t make_entry(input logic [N-1:0] t, input bit clr, input int acc);
    sb_t e;
    logic pass_m;
    pass_m = ((t | fault_mask) == t);
    if (!pass_m) begin
      err_m = 1'b1;
      if (clr)              cnt_m = CW'(1);
      else if (cnt_m != '1) cnt_m = cnt_m + CW'(1);
    end else if (clr) begin
      err_m = 1'b0;
      cnt_m = '0;
    end
    shadow_m  = t;
    e.tgt     = t;
    e.acc     = acc;
    e.exp_err = err_m;
    e.exp_cnt = cnt_m;
    return e;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tgt_if.tgt_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic [N-1:0] t, input logic m, input bit clr);
    logic [N-1:0] ej, ek;
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ready_timeout tgt=%b got ready=%b exp 1", t, tgt_if.tgt_ready);
      return;
    end
    exc(t, shadow_m, m, ej, ek);
    sb.push_back(make_entry(t, clr, cyc + 1));
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_data  = t;
    tgt_if.tgt_mode  = m;
    @(negedge clock);
    tgt_if.tgt_valid = 1'b0;
    checks++;
    if (j !== ej || k !== ek) begin
      errors++;
      $display("FAIL drive_jk tgt=%b mode=%b got j=%b k=%b exp j=%b k=%b", t, m, j, k, ej, ek);
    end
    if (clr) begin
      repeat (1 + SETTLE) @(negedge clock);
      err_clr = 1'b1;
      @(negedge clock);
      err_clr = 1'b0;
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout tgt=%b got pending=%0d exp 0", t, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (j !== 4'b0000 || k !== 4'b1111 || tgt_if.tgt_ready !== 1'b0 || busy !== 1'b1 ||
        done !== 1'b0 || err !== 1'b0 || mismatch_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got j=%b k=%b rdy=%b busy=%b done=%b err=%b cnt=%0d exp 0000 1111 0 1 0 0 0",
               j, k, tgt_if.tgt_ready, busy, done, err, mismatch_count);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (j !== 4'b0000 || k !== 4'b1111 || tgt_if.tgt_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL init_cycle got j=%b k=%b rdy=%b busy=%b exp 0000 1111 0 1", j, k, tgt_if.tgt_ready, busy);
    end
    @(negedge clock);
    checks++;
    if (j !== 4'b0000 || k !== 4'b1111 || tgt_if.tgt_ready !== 1'b1 || busy !== 1'b0 || q_fb !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_init got j=%b k=%b rdy=%b busy=%b q=%b exp 0000 1111 1 0 0000",
               j, k, tgt_if.tgt_ready, busy, q_fb);
    end
  endtask

  task automatic test_mode0();
    send(4'b1010, 1'b0, 1'b0);
    checks++;
    if (q_fb !== 4'b1010) begin
      errors++;
      $display("FAIL mode0_bank got %b exp 1010", q_fb);
    end
  endtask

  task automatic test_mode1();
    send(4'b0110, 1'b1, 1'b0);
    checks++;
    if (q_fb !== 4'b0110 || err !== 1'b0) begin
      errors++;
      $display("FAIL mode1_bank got q=%b err=%b exp 0110 0", q_fb, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ej1, ek1, ej2, ek2;
    int acc1;
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_ready_timeout got ready=%b exp 1", tgt_if.tgt_ready);
      return;
    end
    acc1 = cyc + 1;
    exc(4'b1111, shadow_m, 1'b0, ej1, ek1);
    sb.push_back(make_entry(4'b1111, 1'b0, acc1));
    exc(4'b0001, shadow_m, 1'b0, ej2, ek2);
    sb.push_back(make_entry(4'b0001, 1'b0, acc1 + 3 + SETTLE));
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_data  = 4'b1111;
    tgt_if.tgt_mode  = 1'b0;
    @(negedge clock);
    tgt_if.tgt_data  = 4'b0001;
    checks++;
    if (j !== ej1 || k !== ek1) begin
      errors++;
      $display("FAIL b2b_drive1 got j=%b k=%b exp j=%b k=%b", j, k, ej1, ek1);
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    checks++;
    if (!ok || tgt_if.tgt_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_in_done got done=%b rdy=%b exp 1 1", done, tgt_if.tgt_ready);
    end
    @(negedge clock);
    tgt_if.tgt_valid = 1'b0;
    checks++;
    if (j !== ej2 || k !== ek2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drive2 got j=%b k=%b busy=%b exp j=%b k=%b busy=1", j, k, busy, ej2, ek2);
    end
    wait_drain(ok);
    checks++;
    if (!ok || q_fb !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_drain got pending=%0d q=%b exp 0 0001", sb.size(), q_fb);
      sb.delete();
    end
  endtask

  task automatic test_fault_saturate();
    fault_mask = 4'b0001;
    for (int n = 0; n < 300; n++) send(4'b0000, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || mismatch_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate got err=%b cnt=%0d exp 1 255", err, mismatch_count);
    end
  endtask

  task automatic test_err_clr();
    // Clear coinciding with a failing check: the failure wins with a count of one.
    send(4'b0000, 1'b0, 1'b1);
    fault_mask = 4'b0000;
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    err_m = 1'b0;
    cnt_m = '0;
    checks++;
    if (err !== 1'b0 || mismatch_count !== 8'd0) begin
      errors++;
      $display("FAIL err_clr got err=%b cnt=%0d exp 0 0", err, mismatch_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    wait_ready(ok);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_data  = 4'b1100;
    tgt_if.tgt_mode  = 1'b0;
    @(negedge clock);
    tgt_if.tgt_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (j !== 4'b0000 || k !== 4'b1111 || busy !== 1'b1 || done !== 1'b0 || tgt_if.tgt_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_async got j=%b k=%b busy=%b done=%b rdy=%b exp 0000 1111 1 0 0",
               j, k, busy, done, tgt_if.tgt_ready);
    end
    shadow_m = '0;
    err_m    = 1'b0;
    cnt_m    = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if (j !== 4'b0000 || k !== 4'b1111 || tgt_if.tgt_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_init got j=%b k=%b rdy=%b exp 0000 1111 0", j, k, tgt_if.tgt_ready);
    end
    @(negedge clock);
    checks++;
    if (tgt_if.tgt_ready !== 1'b1 || busy !== 1'b0 || q_fb !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle got rdy=%b busy=%b q=%b exp 1 0 0000", tgt_if.tgt_ready, busy, q_fb);
    end
    // Toggle from a cleared shadow: bits 1:0 toggle, bits 3:2 are held reset.
    send(4'b0011, 1'b1, 1'b0);
    checks++;
    if (q_fb !== 4'b0011) begin
      errors++;
      $display("FAIL post_abort_bank got %b exp 0011", q_fb);
    end
  endtask

  initial begin
    tgt_if.tgt_valid = 1'b0;
    tgt_if.tgt_data  = '0;
    tgt_if.tgt_mode  = 1'b0;
    err_clr          = 1'b0;
    test_reset();
    test_mode0();
    test_mode1();
    test_back_to_back();
    test_fault_saturate();
    test_err_clr();
    test_reset_mid_wait();
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
